char_pos_ctl: RTL and testbench

Character position controller sitting directly upstream of the rectangle/sprite drawing stage: it produces the `x`/`y` top-left coordinates that the drawing stage uses to place a W×H sprite. Position updates once per frame, at the start of vertical blanking, so coordinates stay constant across the whole active frame. Horizontal motion is driven by level left/right controls. Vertical motion is a jump/gravity state machine bounded by the ground line and the top of the screen.

---
 rtl/char_pos_ctl_if.sv | 15 +
 rtl/char_pos_ctl.sv | 165 ++++++++++++++++
 tb/tb_char_pos_ctl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_pos_ctl_if.sv
`default_nettype none
// ============================================================================
// Interface : vga_if
// Purpose   : VGA timing stream as seen by the character position controller.
//             Only the vertical blanking flag is needed downstream of the
//             timing generator, so that is the only member carried here.
// Modports  : in - consumer view, vblnk is an input
// Revision  : 1.0 - initial release
// ============================================================================
interface vga_if;
    logic vblnk;

    modport in (input vblnk);
endinterface
`default_nettype wire

// File: rtl/char_pos_ctl.sv
`default_nettype none
// ============================================================================
// Module    : char_pos_ctl
// Purpose   : Produces the top-left x/y of a W x H sprite. Position is updated
//             once per frame at the rising edge of vertical blanking, so the
//             coordinates are stable for the whole active frame. Horizontal
//             motion follows level left/right controls; vertical motion is a
//             jump/gravity FSM bounded by the ground line and the screen top.
// Ports     : clk        - pixel clock
//             rst        - synchronous active-high reset
//             vga_in     - timing stream (vblnk only)
//             move_left  - level, synchronised
//             move_right - level, synchronised
//             jump       - request pulse of any width, synchronised
//             x, y       - sprite left / top edge, registered
//             airborne   - high while rising or falling
//             frame_tick - one-cycle pulse when new x/y first appear
// Revision  : 1.0 - initial release
// ============================================================================
module char_pos_ctl #(
    parameter int W        = 48,
    parameter int H        = 64,
    parameter int SCREEN_W = 1024,
    parameter int SCREEN_H = 768,
    parameter int X_INIT   = 0,
    parameter int H_SPEED  = 4,
    parameter int JUMP_V0  = 16,
    parameter int GRAVITY  = 1,
    parameter int V_MAX    = 16
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        jump,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        airborne,
    output logic        frame_tick
);

    // All position math is done at 13 bits so sums never wrap.
    localparam logic [12:0] c_GROUND_Y = 13'(SCREEN_H - H);
    localparam logic [12:0] c_X_MAX    = 13'(SCREEN_W - W);
    localparam logic [12:0] c_H_SPEED  = 13'(H_SPEED);
    localparam logic [7:0]  c_JUMP_V0  = 8'(JUMP_V0);
    localparam logic [7:0]  c_GRAVITY  = 8'(GRAVITY);
    localparam logic [12:0] c_V_MAX    = 13'(V_MAX);

    localparam logic [1:0] S_GROUND = 2'd0;
    localparam logic [1:0] S_RISE   = 2'd1;
    localparam logic [1:0] S_FALL   = 2'd2;

    logic        vblnk_q;
    logic        jump_pend_q, jump_pend_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [7:0]  vy_q, vy_d;
    logic [1:0]  state_q, state_d;
    logic        frame_tick_q;

    logic        w_tick;
    logic        w_jump_go;
    logic [12:0] w_x13, w_y13, w_vy13;
    logic [12:0] w_v_sum, w_v_fall;

    assign w_tick    = vga_in.vblnk & ~vblnk_q;
    // A request in the tick cycle itself still counts at that tick.
    assign w_jump_go = jump_pend_q | jump;

    assign w_x13    = {1'b0, x_q};
    assign w_y13    = {1'b0, y_q};
    assign w_vy13   = {5'b0, vy_q};
    assign w_v_sum  = w_vy13 + 13'(GRAVITY);
    assign w_v_fall = (w_v_sum > c_V_MAX) ? c_V_MAX : w_v_sum;

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        vy_d        = vy_q;
        state_d     = state_q;
        // The latch is consumed at every tick, so requests made while
        // airborne are simply dropped.
        jump_pend_d = w_tick ? 1'b0 : w_jump_go;

        if (w_tick) begin
            if (move_left && !move_right) begin
                x_d = (w_x13 >= c_H_SPEED) ? 12'(w_x13 - c_H_SPEED) : 12'd0;
            end else if (move_right && !move_left) begin
                x_d = (w_x13 + c_H_SPEED <= c_X_MAX) ? 12'(w_x13 + c_H_SPEED)
                                                     : 12'(c_X_MAX);
            end

            case (state_q)
                S_GROUND: begin
                    y_d  = 12'(c_GROUND_Y);
                    vy_d = 8'd0;
                    if (w_jump_go) begin
                        state_d = S_RISE;
                        vy_d    = c_JUMP_V0;
                    end
                end
                S_RISE: begin
                    if (w_y13 < w_vy13) begin
                        // Hit the top of the screen: clamp and start falling.
                        y_d     = 12'd0;
                        vy_d    = 8'd0;
                        state_d = S_FALL;
                    end else begin
                        y_d = 12'(w_y13 - w_vy13);
                        if (vy_q <= c_GRAVITY) begin
                            vy_d    = 8'd0;
                            state_d = S_FALL;
                        end else begin
                            vy_d = vy_q - c_GRAVITY;
                        end
                    end
                end
                S_FALL: begin
                    if (w_y13 + w_v_fall >= c_GROUND_Y) begin
                        y_d     = 12'(c_GROUND_Y);
                        vy_d    = 8'd0;
                        state_d = S_GROUND;
                    end else begin
                        y_d  = 12'(w_y13 + w_v_fall);
                        vy_d = 8'(w_v_fall);
                    end
                end
                default: begin
                    y_d     = 12'(c_GROUND_Y);
                    vy_d    = 8'd0;
                    state_d = S_GROUND;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q      <= 1'b0;
            jump_pend_q  <= 1'b0;
            x_q          <= 12'(X_INIT);
            y_q          <= 12'(c_GROUND_Y);
            vy_q         <= 8'd0;
            state_q      <= S_GROUND;
            frame_tick_q <= 1'b0;
        end else begin
            vblnk_q      <= vga_in.vblnk;
            jump_pend_q  <= jump_pend_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vy_q         <= vy_d;
            state_q      <= state_d;
            frame_tick_q <= w_tick;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign airborne   = (state_q != S_GROUND);
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_char_pos_ctl.sv
`default_nettype none
// ============================================================================
// Module    : tb_char_pos_ctl
// Purpose   : Directed self-checking bench for char_pos_ctl. A second instance
//             with a short screen exercises the top-of-screen clamp.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_char_pos_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblnk;
    logic        move_left, move_right, jump;
    logic [11:0] x, y, xs, ys;
    logic        airborne, frame_tick, airborne_s, frame_tick_s;

    int checks = 0;
    int errors = 0;

    // Jump trajectory with defaults: 16 rise ticks then 16 fall ticks.
    int jump_tab [32] = '{688, 673, 659, 646, 634, 623, 613, 604,
                          596, 589, 583, 578, 574, 571, 569, 568,
                          569, 571, 574, 578, 583, 589, 596, 604,
                          613, 623, 634, 646, 659, 673, 688, 704};
    // Short screen (ground at 36): clamps at the top on the 3rd rise tick.
    int small_tab [12] = '{36, 20, 5, 0, 1, 3, 6, 10, 15, 21, 28, 36};

    always #5 clk = ~clk;

    vga_if u_vga ();
    vga_if u_vga_s ();
    assign u_vga.vblnk   = vblnk;
    assign u_vga_s.vblnk = vblnk;

    char_pos_ctl u_dut (
        .clk        (clk),
        .rst        (rst),
        .vga_in     (u_vga),
        .move_left  (move_left),
        .move_right (move_right),
        .jump       (jump),
        .x          (x),
        .y          (y),
        .airborne   (airborne),
        .frame_tick (frame_tick)
    );

    char_pos_ctl #(.SCREEN_H(100), .H(64)) u_dut_s (
        .clk        (clk),
        .rst        (rst),
        .vga_in     (u_vga_s),
        .move_left  (move_left),
        .move_right (move_right),
        .jump       (jump),
        .x          (xs),
        .y          (ys),
        .airborne   (airborne_s),
        .frame_tick (frame_tick_s)
    );

    // One frame: 6 active cycles then the vblnk rise. Returns #1 after the
    // edge on which the tick is registered, i.e. when new outputs appear.
    task automatic next_frame(input bit jmp_mid, input bit jmp_tick);
        vblnk = 1'b0;
        for (int i = 0; i < 6; i++) begin
            jump = jmp_mid && (i == 2);
            @(posedge clk); #1;
        end
        jump  = jmp_tick;
        vblnk = 1'b1;
        @(posedge clk); #1;
        jump  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vblnk = 1'b0; move_left = 1'b0; move_right = 1'b0; jump = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (x !== 12'd0 || y !== 12'd704 || airborne !== 1'b0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: x=%0d y=%0d air=%b tick=%b, want 0 704 0 0",
                     x, y, airborne, frame_tick);
        end
        rst = 1'b0;
        for (int f = 0; f < 3; f++) begin
            next_frame(1'b0, 1'b0);
            checks++;
            if (x !== 12'd0 || y !== 12'd704 || airborne !== 1'b0 || frame_tick !== 1'b1) begin
                errors++;
                $display("FAIL idle_frame%0d: x=%0d y=%0d air=%b tick=%b, want 0 704 0 1",
                         f, x, y, airborne, frame_tick);
            end
            @(posedge clk); #1;
            checks++;
            if (frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL tick_width%0d: tick=%b, want 0", f, frame_tick);
            end
        end
    endtask

    task automatic test_horizontal();
        int xe;
        xe = 0;
        move_right = 1'b1;
        for (int f = 0; f < 300; f++) begin
            next_frame(1'b0, 1'b0);
            xe = (xe + 4 <= 976) ? xe + 4 : 976;
            checks++;
            if (x !== 12'(xe)) begin
                errors++;
                $display("FAIL right_f%0d: x=%0d, want %0d", f, x, xe);
            end
        end
        move_right = 1'b0; move_left = 1'b1;
        for (int f = 0; f < 300; f++) begin
            next_frame(1'b0, 1'b0);
            xe = (xe >= 4) ? xe - 4 : 0;
            checks++;
            if (x !== 12'(xe)) begin
                errors++;
                $display("FAIL left_f%0d: x=%0d, want %0d", f, x, xe);
            end
        end
        move_left = 1'b0; move_right = 1'b1;
        repeat (10) next_frame(1'b0, 1'b0);
        checks++;
        if (x !== 12'd40) begin
            errors++;
            $display("FAIL right10: x=%0d, want 40", x);
        end
        move_left = 1'b1;
        for (int f = 0; f < 5; f++) begin
            next_frame(1'b0, 1'b0);
            checks++;
            if (x !== 12'd40) begin
                errors++;
                $display("FAIL both_hold_f%0d: x=%0d, want 40", f, x);
            end
        end
        move_left = 1'b0; move_right = 1'b0;
    endtask

    task automatic test_jump();
        next_frame(1'b1, 1'b0);
        checks++;
        if (airborne !== 1'b1 || y !== 12'd704) begin
            errors++;
            $display("FAIL jump_start: air=%b y=%0d, want 1 704", airborne, y);
        end
        for (int k = 0; k < 32; k++) begin
            next_frame(1'b0, 1'b0);
            checks++;
            if (y !== 12'(jump_tab[k]) || airborne !== (k < 31)) begin
                errors++;
                $display("FAIL jump_f%0d: y=%0d air=%b, want %0d %b",
                         k, y, airborne, jump_tab[k], (k < 31));
            end
        end
    endtask

    task automatic test_no_double_jump();
        next_frame(1'b1, 1'b0);
        for (int k = 0; k < 32; k++) begin
            next_frame((k == 4) || (k == 24), 1'b0);
            checks++;
            if (y !== 12'(jump_tab[k]) || airborne !== (k < 31)) begin
                errors++;
                $display("FAIL nodbl_f%0d: y=%0d air=%b, want %0d %b",
                         k, y, airborne, jump_tab[k], (k < 31));
            end
        end
        next_frame(1'b0, 1'b0);
        checks++;
        if (airborne !== 1'b0 || y !== 12'd704) begin
            errors++;
            $display("FAIL nodbl_landed: air=%b y=%0d, want 0 704", airborne, y);
        end
        next_frame(1'b1, 1'b0);
        next_frame(1'b0, 1'b0);
        checks++;
        if (airborne !== 1'b1 || y !== 12'd688) begin
            errors++;
            $display("FAIL rejump: air=%b y=%0d, want 1 688", airborne, y);
        end
        repeat (31) next_frame(1'b0, 1'b0);
        checks++;
        if (airborne !== 1'b0 || y !== 12'd704) begin
            errors++;
            $display("FAIL rejump_land: air=%b y=%0d, want 0 704", airborne, y);
        end
    endtask

    task automatic test_jump_in_tick();
        next_frame(1'b0, 1'b1);
        checks++;
        if (airborne !== 1'b1 || y !== 12'd704) begin
            errors++;
            $display("FAIL tick_jump: air=%b y=%0d, want 1 704", airborne, y);
        end
        next_frame(1'b0, 1'b0);
        next_frame(1'b0, 1'b0);
        checks++;
        if (y !== 12'd673) begin
            errors++;
            $display("FAIL tick_jump_rise: y=%0d, want 673", y);
        end
    endtask

    task automatic test_reset_mid_jump();
        // vblnk is still high from the last frame and stays high across reset.
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (x !== 12'd0 || y !== 12'd704 || airborne !== 1'b0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL midjump_reset: x=%0d y=%0d air=%b tick=%b, want 0 704 0 0",
                     x, y, airborne, frame_tick);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (frame_tick !== 1'b1 || x !== 12'd0 || y !== 12'd704 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_tick: tick=%b x=%0d y=%0d air=%b, want 1 0 704 0",
                     frame_tick, x, y, airborne);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL vblnk_high_tick%0d: tick=%b, want 0", i, frame_tick);
            end
        end
        next_frame(1'b0, 1'b0);
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL next_rise_tick: tick=%b, want 1", frame_tick);
        end
    endtask

    task automatic test_top_clamp();
        next_frame(1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) next_frame(1'b0, 1'b0);
            checks++;
            if (ys !== 12'(small_tab[k]) || airborne_s !== (k < 11)) begin
                errors++;
                $display("FAIL clamp_f%0d: y=%0d air=%b, want %0d %b",
                         k, ys, airborne_s, small_tab[k], (k < 11));
            end
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_jump();
        test_no_double_jump();
        test_jump_in_tick();
        test_reset_mid_jump();
        test_top_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
